mem_checker: RTL and testbench

MEM_CHECKER -- requirements
Module: mem_checker

---
 rtl/mem_checker_pkg.sv | 24 ++
 rtl/mem_chk_cmp.sv | 35 +++
 rtl/mem_checker.sv | 124 ++++++++++++
 tb/tb_mem_checker.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_checker_pkg.sv
// Shared types and defaults for the memory checker.
// No logic; constants, the state enumeration and a saturating-increment helper.
// Imported by mem_checker and mem_chk_cmp.
package mem_checker_pkg;

  localparam int DEPTH_DEF = 8;
  localparam int AW_DEF    = 3;
  localparam int DW_DEF    = 4;
  localparam int ERR_W     = 4;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    CMP,
    DONE
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
  endfunction

endpackage

// File: rtl/mem_chk_cmp.sv
// Registered read-data compare with saturating error count and first-fail capture.
// Latency: result visible the cycle after cmp_en is sampled.
// No backpressure; compares whenever cmp_en is high.
module mem_chk_cmp
  import mem_checker_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             cmp_en,
  input  logic [AW-1:0]    cmp_addr,
  input  logic [DW-1:0]    exp_data,
  input  logic [DW-1:0]    rd_data,
  output logic [ERR_W-1:0] err_count,
  output logic [AW-1:0]    fail_addr
);

  // Count mismatches; the count never returns to zero within a run, so a
  // zero count marks the first mismatch for fail_addr capture.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      err_count <= '0;
      fail_addr <= '0;
    end else if (cmp_en && (rd_data != exp_data)) begin
      err_count <= sat_inc(err_count);
      if (err_count == '0) begin
        fail_addr <= cmp_addr;
      end
    end
  end

endmodule

// File: rtl/mem_checker.sv
// Write-then-read RAM checker: fills DEPTH words with pattern^addr, reads back, counts mismatches.
// Latency: start accepted at edge 0 -> done sampled at edge 2*DEPTH+2.
// No backpressure; start is ignored while a run is in progress.
module mem_checker
  import mem_checker_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DW-1:0]    pattern,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [AW-1:0]    fail_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] pat_q;
  logic          pass_q;
  logic          start_acc;
  logic          cmp_en;
  logic [AW-1:0] cmp_addr;
  logic [DW-1:0] exp_data;

  // State, address counter, captured seed and held pass result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start_acc) begin
        pat_q  <= pattern;
        pass_q <= 1'b0;
      end else if (state_q == DONE) begin
        pass_q <= (err_count == '0);
      end
    end
  end

  // Next state and counter; the counter stops at LAST and never leaves range.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = WRITE;
          cnt_d     = '0;
        end
      end
      WRITE: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = READ;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      READ: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = CMP;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      CMP:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM side and status outputs; reset gates the write strobe immediately.
  always_comb begin
    mem_we    = (state_q == WRITE) && !reset;
    mem_addr  = cnt_q;
    mem_wdata = (state_q == WRITE) ? (pat_q ^ DW'(cnt_q)) : '0;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    pass      = (state_q == DONE) ? (err_count == '0) : pass_q;
  end

  // Read data lags the address by one cycle, so compare against the previous
  // address during READ and against the last address in CMP.
  always_comb begin
    cmp_en   = ((state_q == READ) && (cnt_q != '0)) || (state_q == CMP);
    cmp_addr = (state_q == CMP) ? LAST : (cnt_q - AW'(1));
    exp_data = pat_q ^ DW'(cmp_addr);
  end

  mem_chk_cmp #(
    .AW(AW),
    .DW(DW)
  ) u_cmp (
    .clk       (clk),
    .reset     (reset),
    .clr       (start_acc),
    .cmp_en    (cmp_en),
    .cmp_addr  (cmp_addr),
    .exp_data  (exp_data),
    .rd_data   (mem_rdata),
    .err_count (err_count),
    .fail_addr (fail_addr)
  );

endmodule

// File: tb/tb_mem_checker.sv
// Scoreboard bench for mem_checker: 8-deep instance with a fault-injecting RAM,
// plus a 16-deep instance whose RAM corrupts every read.
// Expected results are queued at start; monitors compare on done / mem_we.
module tb_mem_checker;

  typedef struct {
    int done_edge;
    int pass;
    int err;
    int fail;
  } res_t;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- 8-deep DUT ----------------
  logic       start8;
  logic [3:0] pattern8;
  logic       we8;
  logic [2:0] addr8;
  logic [3:0] wdata8;
  logic [3:0] rdata8 = 4'h0;
  logic       busy8, done8, pass8;
  logic [3:0] err8;
  logic [2:0] fail8;
  int         mode8;
  logic [3:0] ram8 [8];

  mem_checker dut8 (
    .clk(clk), .reset(reset), .start(start8), .pattern(pattern8),
    .mem_we(we8), .mem_addr(addr8), .mem_wdata(wdata8), .mem_rdata(rdata8),
    .busy(busy8), .done(done8), .pass(pass8), .err_count(err8), .fail_addr(fail8)
  );

  // mode 0 ideal, 1 bit0 stuck-at-0 at address 5, 2 always returns F
  always @(posedge clk) begin
    if (we8) ram8[addr8] <= wdata8;
    case (mode8)
      0:       rdata8 <= ram8[addr8];
      1:       rdata8 <= (addr8 == 3'd5) ? (ram8[addr8] & 4'hE) : ram8[addr8];
      default: rdata8 <= 4'hF;
    endcase
  end

  // ---------------- 16-deep DUT ----------------
  logic       start16;
  logic [3:0] pattern16;
  logic       we16;
  logic [3:0] addr16;
  logic [3:0] wdata16;
  logic [3:0] rdata16 = 4'h0;
  logic       busy16, done16, pass16;
  logic [3:0] err16;
  logic [3:0] fail16;
  logic [3:0] ram16 [16];

  mem_checker #(.DEPTH(16), .AW(4), .DW(4)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .pattern(pattern16),
    .mem_we(we16), .mem_addr(addr16), .mem_wdata(wdata16), .mem_rdata(rdata16),
    .busy(busy16), .done(done16), .pass(pass16), .err_count(err16), .fail_addr(fail16)
  );

  // every read returns the inverted word
  always @(posedge clk) begin
    if (we16) ram16[addr16] <= wdata16;
    rdata16 <= ~ram16[addr16];
  end

  // ---------------- scoreboard ----------------
  res_t q8[$];
  res_t q16[$];
  wr_t  wq8[$];
  bit   wr_chk8 = 1'b0;
  int   done8_cnt = 0;
  int   done16_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // done is sampled at the following edge, hence edge_n+1
  always @(negedge clk) begin
    res_t r;
    if (done8) begin
      done8_cnt++;
      if (q8.size() == 0) begin
        chk("done8_unexpected", 1, 0);
      end else begin
        r = q8.pop_front();
        chk("done8_edge", edge_n + 1, r.done_edge);
        chk("pass8", int'(pass8), r.pass);
        chk("err8", int'(err8), r.err);
        chk("fail8", int'(fail8), r.fail);
      end
    end
    if (we8 && wr_chk8) begin
      if (wq8.size() == 0) begin
        chk("wr8_unexpected", 1, 0);
      end else begin
        wr_t w;
        w = wq8.pop_front();
        chk("wr8_addr", int'(addr8), w.addr);
        chk("wr8_data", int'(wdata8), w.data);
      end
    end
  end

  always @(negedge clk) begin
    res_t r;
    if (done16) begin
      done16_cnt++;
      if (q16.size() == 0) begin
        chk("done16_unexpected", 1, 0);
      end else begin
        r = q16.pop_front();
        chk("done16_edge", edge_n + 1, r.done_edge);
        chk("pass16", int'(pass16), r.pass);
        chk("err16", int'(err16), r.err);
        chk("fail16", int'(fail16), r.fail);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic run8(input logic [3:0] pat, input int mode, input int p,
                      input int e, input int f, output int s);
    @(negedge clk);
    mode8    = mode;
    pattern8 = pat;
    start8   = 1'b1;
    @(posedge clk);
    #1;
    start8   = 1'b0;
    pattern8 = ~pat;     // captured seed must not follow the input
    s = edge_n;
    q8.push_back('{s + 18, p, e, f});
    chk("busy8_after_start", int'(busy8), 1);
    chk("pass8_cleared", int'(pass8), 0);
  endtask

  task automatic push_xor_writes(input logic [3:0] pat);
    for (int i = 0; i < 8; i++) begin
      logic [3:0] a;
      a = 4'(i);
      wq8.push_back('{i, int'(pat ^ a)});
    end
  endtask

  task automatic drain8(input string name);
    int n = 0;
    while (q8.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(name, q8.size(), 0);
    q8.delete();
    @(negedge clk);
    chk({name, "_writes"}, wq8.size(), 0);
    wq8.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int s;
    int dc;
    int wtab[8] = '{4, 5, 6, 7, 0, 1, 2, 3};
    reset     = 1'b1;
    start8    = 1'b0;
    start16   = 1'b0;
    pattern8  = 4'h0;
    pattern16 = 4'h0;
    mode8     = 0;
    repeat (3) @(negedge clk);
    start8 = 1'b1;                     // reset must win over start
    @(negedge clk);
    chk("rst_we8", int'(we8), 0);
    chk("rst_addr8", int'(addr8), 0);
    chk("rst_wdata8", int'(wdata8), 0);
    chk("rst_busy8", int'(busy8), 0);
    chk("rst_done8", int'(done8), 0);
    chk("rst_pass8", int'(pass8), 0);
    chk("rst_err8", int'(err8), 0);
    chk("rst_fail8", int'(fail8), 0);
    chk("rst_busy16", int'(busy16), 0);
    start8 = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    chk("idle_busy8", int'(busy8), 0);

    // ideal RAM, seed 4: writes 4,5,6,7,0,1,2,3; pass
    for (int i = 0; i < 8; i++) wq8.push_back('{i, wtab[i]});
    wr_chk8 = 1'b1;
    run8(4'h4, 0, 1, 0, 0, s);
    drain8("t1_drain");
    repeat (3) @(negedge clk);
    chk("t1_pass_held", int'(pass8), 1);
    chk("t1_busy_idle", int'(busy8), 0);

    // bit0 stuck-at-0 at address 5 only
    push_xor_writes(4'h4);
    run8(4'h4, 1, 0, 1, 5, s);
    drain8("t2_drain");
    repeat (2) @(negedge clk);
    chk("t2_pass_held", int'(pass8), 0);
    chk("t2_err_held", int'(err8), 1);

    // RAM always F, seed 0: all eight reads wrong
    push_xor_writes(4'h0);
    run8(4'h0, 2, 0, 8, 0, s);
    drain8("t3_drain");

    // 16-deep, every read corrupted: count saturates at 15
    @(negedge clk);
    pattern16 = 4'hA;
    start16   = 1'b1;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    s = edge_n;
    q16.push_back('{s + 34, 0, 15, 0});
    begin
      int n = 0;
      while (q16.size() != 0 && n < 80) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t4_drain", q16.size(), 0);
    q16.delete();
    chk("t4_done_count", done16_cnt, 1);

    // reset in the 4th WRITE cycle aborts the run with no done pulse
    wr_chk8 = 1'b0;
    dc = done8_cnt;
    @(negedge clk);
    mode8    = 0;
    pattern8 = 4'h7;
    start8   = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t5_in_write", int'(busy8), 1);
    reset = 1'b1;
    #1;
    chk("t5_we_gated", int'(we8), 0);
    @(posedge clk);
    #1;
    chk("t5_busy_after_rst", int'(busy8), 0);
    chk("t5_we_after_rst", int'(we8), 0);
    chk("t5_addr_after_rst", int'(addr8), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    chk("t5_no_done", done8_cnt, dc);
    wr_chk8 = 1'b1;
    push_xor_writes(4'h9);
    run8(4'h9, 0, 1, 0, 0, s);
    drain8("t5_drain");

    // start re-asserted during READ is ignored
    dc = done8_cnt;
    push_xor_writes(4'h3);
    run8(4'h3, 0, 1, 0, 0, s);
    repeat (10) @(posedge clk);
    @(negedge clk);
    start8   = 1'b1;
    pattern8 = 4'hC;
    repeat (3) @(negedge clk);
    chk("t6_busy_in_read", int'(busy8), 1);
    start8 = 1'b0;
    drain8("t6_drain");
    repeat (20) @(negedge clk);
    chk("t6_single_done", done8_cnt, dc + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
